gate_truth_table_checker: RTL and testbench

//   Stimulus and response end for a 2-input gate under test.
//   On start, drives the four {in0,in1} vectors 00,01,10,11 in order.

---
 rtl/gate_truth_table_checker_if.sv | 24 ++
 rtl/gate_truth_table_checker.sv | 116 +++++++++++
 tb/tb_gate_truth_table_checker.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_truth_table_checker_if.sv
// Signal bundle between the truth-table checker and whatever drives start and
// returns the gate output.
interface gate_truth_table_checker_if;
    logic       start;
    logic       dut_out;
    logic       in0;
    logic       in1;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] truth_table;
    logic [3:0] mismatch;

    // The controller requests runs and closes the loop through the gate.
    modport master (
        output start, dut_out,
        input  in0, in1, busy, done, pass, truth_table, mismatch
    );

    modport slave (
        input  start, dut_out,
        output in0, in1, busy, done, pass, truth_table, mismatch
    );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Walks a 2-input gate through vectors 00..11, samples its output after a
// settle time, and compares the captured truth table with EXPECTED.
module gate_truth_table_checker #(
    parameter int         SETTLE_CYCLES = 4,
    parameter int         CNT_W         = 8,
    parameter logic [3:0] EXPECTED      = 4'b0000
) (
    input logic                        clk,
    input logic                        rst_n,
    gate_truth_table_checker_if.slave  bus
);

    function automatic int settle_clamp(input int cycles);
        return (cycles < 1) ? 1 : cycles;
    endfunction

    localparam int               SETTLE_EFF = settle_clamp(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;
    logic             pass, pass_nxt;
    logic [3:0]       tt, tt_nxt, tt_new;
    logic [3:0]       mm, mm_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 2'd0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
            tt    <= 4'd0;
            mm    <= 4'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            pass  <= pass_nxt;
            tt    <= tt_nxt;
            mm    <= mm_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        busy_nxt    = busy;
        done_nxt    = done;
        pass_nxt    = pass;
        tt_nxt      = tt;
        mm_nxt      = mm;
        // Table as it will look once the current vector's sample lands.
        tt_new      = tt;
        tt_new[idx] = bus.dut_out;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SETTLE;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    pass_nxt  = 1'b0;
                    tt_nxt    = 4'd0;
                    mm_nxt    = 4'd0;
                end
            end
            SETTLE: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                tt_nxt = tt_new;
                if (idx == 2'd3) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (tt_new == EXPECTED);
                    mm_nxt    = tt_new ^ EXPECTED;
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + 2'd1;
                    state_nxt = SETTLE;
                end
            end
            DONE: begin
                done_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // idx doubles as the applied vector; it rests at 11 after a run.
    assign bus.in0         = idx[1];
    assign bus.in1         = idx[0];
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.pass        = pass;
    assign bus.truth_table = tt;
    assign bus.mismatch    = mm;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: three parameterisations, table vectors,
// hand-written corner sequences and random gates against a cycle-level model.
module tb_gate_truth_table_checker;

    localparam int         S_A = 4;
    localparam int         S_B = 1;
    localparam int         S_C = 0;
    localparam logic [3:0] E_A = 4'b0000;
    localparam logic [3:0] E_B = 4'b0110;
    localparam logic [3:0] E_C = 4'b1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gate_truth_table_checker_if ifa ();
    gate_truth_table_checker_if ifb ();
    gate_truth_table_checker_if ifc ();

    // Each gate under test is an arbitrary 2-input function held as a 4-bit table.
    logic [3:0] gate_a, gate_b, gate_c;
    assign ifa.dut_out = gate_a[{ifa.in0, ifa.in1}];
    assign ifb.dut_out = gate_b[{ifb.in0, ifb.in1}];
    assign ifc.dut_out = gate_c[{ifc.in0, ifc.in1}];

    gate_truth_table_checker #(.SETTLE_CYCLES(S_A), .CNT_W(8), .EXPECTED(E_A))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    gate_truth_table_checker #(.SETTLE_CYCLES(S_B), .CNT_W(8), .EXPECTED(E_B))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    gate_truth_table_checker #(.SETTLE_CYCLES(S_C), .CNT_W(4), .EXPECTED(E_C))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 0;

    logic [1:0] o_vec;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_tt, o_mm;

    always_comb begin
        o_vec  = {ifa.in0, ifa.in1};
        o_busy = ifa.busy;
        o_done = ifa.done;
        o_pass = ifa.pass;
        o_tt   = ifa.truth_table;
        o_mm   = ifa.mismatch;
        case (sel)
            1: begin
                o_vec = {ifb.in0, ifb.in1}; o_busy = ifb.busy; o_done = ifb.done;
                o_pass = ifb.pass; o_tt = ifb.truth_table; o_mm = ifb.mismatch;
            end
            2: begin
                o_vec = {ifc.in0, ifc.in1}; o_busy = ifc.busy; o_done = ifc.done;
                o_pass = ifc.pass; o_tt = ifc.truth_table; o_mm = ifc.mismatch;
            end
            default: ;
        endcase
    end

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d, t=%0t): got %b expected %b", nm, sel, $time, act, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        case (sel)
            1:       ifb.start = v;
            2:       ifc.start = v;
            default: ifa.start = v;
        endcase
    endtask

    task automatic set_gate(input logic [3:0] g);
        case (sel)
            1:       gate_b = g;
            2:       gate_c = g;
            default: gate_a = g;
        endcase
    endtask

    // Model: cycles per vector is settle time (at least 1) plus the sample cycle.
    function automatic int period_of(input int s);
        int st;
        st = (s == 1) ? S_B : (s == 2) ? S_C : S_A;
        return ((st < 1) ? 1 : st) + 1;
    endfunction

    function automatic logic [3:0] exp_of(input int s);
        return (s == 1) ? E_B : (s == 2) ? E_C : E_A;
    endfunction

    function automatic logic gate_eval(input logic [3:0] g, input logic a, input logic b);
        int row;
        row = a * 2 + b;
        return g[row];
    endfunction

    // One run: start pulse, then per-cycle checks until one cycle past done.
    task automatic do_run(input int s, input logic [3:0] g, input logic [3:0] e_tt,
                          input logic e_pass, input logic [3:0] e_mm, input bit extras);
        int p;
        int v;
        sel = s;
        p   = period_of(s);
        set_gate(g);
        @(negedge clk); drive_start(1'b1);
        @(negedge clk); drive_start(1'b0);
        for (int k = 0; k <= 4 * p + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (extras && (k == 3 || k == 12) && k < 4 * p) drive_start(1'b1);
            else drive_start(1'b0);
            v = (k / p > 3) ? 3 : k / p;
            check("vec", {2'b00, o_vec}, 4'(v));
            check("busy", {3'b000, o_busy}, {3'b000, k < 4 * p});
            check("done", {3'b000, o_done}, {3'b000, k == 4 * p});
            if (k < 4 * p) begin
                check("pass_run", {3'b000, o_pass}, 4'd0);
                check("mm_run", o_mm, 4'd0);
            end else begin
                check("tt", o_tt, e_tt);
                check("mm", o_mm, e_mm);
                check("pass", {3'b000, o_pass}, {3'b000, e_pass});
            end
        end
        drive_start(1'b0);
    endtask

    typedef struct {
        int         s;
        logic [3:0] gate;
        logic [3:0] tt;
        logic       pass;
        logic [3:0] mm;
        bit         extras;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [3:0] g, e, mt;
        int         s, per;

        tbl[0] = '{0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0};  // constant 0
        tbl[1] = '{0, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1};  // AND, stray starts
        tbl[2] = '{1, 4'b0110, 4'b0110, 1'b1, 4'b0000, 1'b0};  // XOR
        tbl[3] = '{1, 4'b1000, 4'b1000, 1'b0, 4'b1110, 1'b0};  // AND vs XOR table
        tbl[4] = '{0, 4'b1110, 4'b1110, 1'b0, 4'b1110, 1'b0};  // OR
        tbl[5] = '{2, 4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0};  // AND, settle clamped to 1
        tbl[6] = '{2, 4'b0001, 4'b0001, 1'b0, 4'b1001, 1'b1};  // NOR
        tbl[7] = '{0, 4'b1111, 4'b1111, 1'b0, 4'b1111, 1'b0};  // constant 1

        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
        gate_a = 4'd0; gate_b = 4'd0; gate_c = 4'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #0;
            check("rst_vec", {2'b00, o_vec}, 4'd0);
            check("rst_busy", {3'b000, o_busy}, 4'd0);
            check("rst_done", {3'b000, o_done}, 4'd0);
            check("rst_pass", {3'b000, o_pass}, 4'd0);
            check("rst_tt", o_tt, 4'd0);
            check("rst_mm", o_mm, 4'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_run(tbl[i].s, tbl[i].gate, tbl[i].tt, tbl[i].pass, tbl[i].mm, tbl[i].extras);
            if (i == 1) begin
                // Failing result must persist through idle time.
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    check("hold_pass", {3'b000, o_pass}, 4'd0);
                    check("hold_mm", o_mm, 4'b1000);
                    check("hold_tt", o_tt, 4'b1000);
                    check("hold_busy", {3'b000, o_busy}, 4'd0);
                    check("hold_done", {3'b000, o_done}, 4'd0);
                end
            end
        end

        // Asynchronous reset in the middle of a run.
        sel = 0;
        gate_a = 4'b1000;
        @(negedge clk); drive_start(1'b1);
        @(negedge clk); drive_start(1'b0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec", {2'b00, o_vec}, 4'd0);
        check("arst_busy", {3'b000, o_busy}, 4'd0);
        check("arst_pass", {3'b000, o_pass}, 4'd0);
        check("arst_tt", o_tt, 4'd0);
        check("arst_mm", o_mm, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle", {3'b000, o_busy}, 4'd0);
        do_run(0, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b0);

        // Start held high: back-to-back runs with a DONE+IDLE gap between them.
        sel = 0;
        gate_a = 4'b0000;
        per = 4 * period_of(0);
        @(negedge clk); drive_start(1'b1);
        @(negedge clk);
        for (int k = 0; k <= 3 * (per + 2) - 1; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 49) drive_start(1'b0);
            check("b2b_busy", {3'b000, o_busy}, {3'b000, (k % (per + 2)) < per});
            check("b2b_done", {3'b000, o_done}, {3'b000, (k % (per + 2)) == per});
        end
        repeat (3) begin
            @(negedge clk);
            check("b2b_idle", {3'b000, o_busy}, 4'd0);
        end

        // Random gates checked against the truth-table model.
        for (int r = 0; r < 24; r++) begin
            s  = $urandom_range(0, 2);
            g  = 4'($urandom);
            e  = exp_of(s);
            mt = 4'd0;
            for (int row = 0; row < 4; row++)
                mt[row] = gate_eval(g, row[1], row[0]);
            do_run(s, g, mt, mt == e, mt ^ e, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
